ddr3_cmd_issue: RTL and testbench

DDR3_CMD_ISSUE -- requirements
Module: ddr3_cmd_issue

---
 rtl/ddr3_cmd_issue.sv | 229 ++++++++++++++++++++++
 tb/tb_ddr3_cmd_issue.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | ddr3_cmd_issue: DDR3 command issue with power-state FSM, global/per-bank timing |
// | guards and registered pins. Build macro: DDR3_CMD_CHECK_EN.   Revision: 1.0    |
// +--------------------------------------------------------------------------------+
module ddr3_cmd_issue #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 16,
  parameter int T_MRD     = 4,
  parameter int T_RCD     = 6,
  parameter int T_RP      = 6,
  parameter int T_RFC     = 64,
  parameter int T_ZQCS    = 64,
  parameter int T_ZQCL    = 256,
  parameter int T_XP      = 4
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [3:0]           req_cmd,
  input  logic [BA_BITS-1:0]   req_ba,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 req_ready,
  output logic                 err,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [BA_BITS-1:0]   ba,
  output logic [ADDR_BITS-1:0] addr
);

  localparam int NB = 1 << BA_BITS;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max_of(max_of(max_of(T_MRD, T_RCD), max_of(T_RP, T_RFC)),
                                max_of(max_of(T_ZQCS, T_ZQCL), T_XP));
  localparam int CW    = $clog2(T_MAX + 1);

`ifdef DDR3_CMD_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_MRS  = 4'd1;
  localparam logic [3:0] C_REF  = 4'd2;
  localparam logic [3:0] C_PRE  = 4'd3;
  localparam logic [3:0] C_PREA = 4'd4;
  localparam logic [3:0] C_ACT  = 4'd5;
  localparam logic [3:0] C_WR   = 4'd6;
  localparam logic [3:0] C_WRAP = 4'd7;
  localparam logic [3:0] C_RD   = 4'd8;
  localparam logic [3:0] C_RDAP = 4'd9;
  localparam logic [3:0] C_ZQCL = 4'd10;
  localparam logic [3:0] C_ZQCS = 4'd11;
  localparam logic [3:0] C_SRE  = 4'd12;
  localparam logic [3:0] C_SRX  = 4'd13;
  localparam logic [3:0] C_PDE  = 4'd14;
  localparam logic [3:0] C_PDX  = 4'd15;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_PWRDN   = 2'd1,
    ST_SELFREF = 2'd2
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_busy;
  logic [CW-1:0]        r_rcd [NB];
  logic [CW-1:0]        r_rp  [NB];
  logic [NB-1:0]        r_open;

  logic [NB-1:0]        w_rcd_ok;
  logic [NB-1:0]        w_rp_ok;
  logic                 w_busy_ok;
  logic                 w_bank_open;
  logic                 w_all_closed;
  logic                 w_rdwr;
  logic                 w_drop;
  logic                 w_acc;
  logic [3:0]           w_pins;
  logic [ADDR_BITS-1:0] w_addr;

  // A counter value of 1 means the guarded cycle n+T has been reached.
  generate
    for (genvar b = 0; b < NB; b++) begin : g_bank
      assign w_rcd_ok[b] = (r_rcd[b] <= CW'(1));
      assign w_rp_ok[b]  = (r_rp[b]  <= CW'(1));
    end
  endgenerate

  always_comb begin
    w_busy_ok    = (r_busy <= CW'(1));
    w_bank_open  = r_open[req_ba];
    w_all_closed = (r_open == '0);
    w_rdwr       = (req_cmd == C_WR) || (req_cmd == C_WRAP) ||
                   (req_cmd == C_RD) || (req_cmd == C_RDAP);
    w_drop       = (r_state == ST_ACTIVE) &&
                   (((req_cmd == C_ACT) && w_bank_open) || (w_rdwr && !w_bank_open));
    req_ready    = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        case (req_cmd)
          C_NOP:                                 req_ready = 1'b1;
          C_MRS, C_REF, C_ZQCL, C_ZQCS,
          C_SRE, C_PDE:                          req_ready = w_busy_ok && w_all_closed;
          C_PRE, C_PREA:                         req_ready = w_busy_ok;
          C_ACT:                                 req_ready = w_busy_ok &&
                                                   (w_bank_open ? CHECK_EN : w_rp_ok[req_ba]);
          C_WR, C_WRAP, C_RD, C_RDAP:            req_ready = w_busy_ok &&
                                                   (w_bank_open ? w_rcd_ok[req_ba] : CHECK_EN);
          default:                               req_ready = 1'b0;
        endcase
      end
      ST_PWRDN:   req_ready = (req_cmd == C_PDX) && w_busy_ok;
      ST_SELFREF: req_ready = (req_cmd == C_SRX) && w_busy_ok;
      default:    req_ready = 1'b0;
    endcase
  end

  assign w_acc = req_valid && req_ready;

  always_comb begin
    w_pins = 4'b0111;
    w_addr = req_addr;
    case (req_cmd)
      C_MRS:        w_pins = 4'b0000;
      C_REF, C_SRE: w_pins = 4'b0001;
      C_PRE:  begin w_pins = 4'b0010; w_addr[10] = 1'b0; end
      C_PREA: begin w_pins = 4'b0010; w_addr[10] = 1'b1; end
      C_ACT:        w_pins = 4'b0011;
      C_WR:   begin w_pins = 4'b0100; w_addr[10] = 1'b0; end
      C_WRAP: begin w_pins = 4'b0100; w_addr[10] = 1'b1; end
      C_RD:   begin w_pins = 4'b0101; w_addr[10] = 1'b0; end
      C_RDAP: begin w_pins = 4'b0101; w_addr[10] = 1'b1; end
      C_ZQCS: begin w_pins = 4'b0110; w_addr[10] = 1'b0; end
      C_ZQCL: begin w_pins = 4'b0110; w_addr[10] = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state <= ST_PWRDN;
      cke     <= 1'b0;
      cs_n    <= 1'b1;
      ras_n   <= 1'b1;
      cas_n   <= 1'b1;
      we_n    <= 1'b1;
      ba      <= '0;
      addr    <= '0;
      r_busy  <= '0;
      r_open  <= '0;
      for (int b = 0; b < NB; b++) begin
        r_rcd[b] <= '0;
        r_rp[b]  <= '0;
      end
    end else begin
      if (r_busy != '0) r_busy <= r_busy - CW'(1);
      for (int b = 0; b < NB; b++) begin
        if (r_rcd[b] != '0) r_rcd[b] <= r_rcd[b] - CW'(1);
        if (r_rp[b]  != '0) r_rp[b]  <= r_rp[b]  - CW'(1);
      end
      // Idle cycles: NOP while active, deselect while CKE is low.
      cs_n  <= (r_state != ST_ACTIVE);
      ras_n <= 1'b1;
      cas_n <= 1'b1;
      we_n  <= 1'b1;
      ba    <= '0;
      addr  <= '0;
      if (w_acc && !w_drop) begin
        {cs_n, ras_n, cas_n, we_n} <= w_pins;
        ba   <= req_ba;
        addr <= w_addr;
        case (req_cmd)
          C_MRS:  r_busy <= CW'(T_MRD);
          C_REF:  r_busy <= CW'(T_RFC);
          C_ZQCS: r_busy <= CW'(T_ZQCS);
          C_ZQCL: r_busy <= CW'(T_ZQCL);
          C_SRX, C_PDX: begin
            r_busy  <= CW'(T_XP);
            cke     <= 1'b1;
            r_state <= ST_ACTIVE;
          end
          C_SRE: begin
            cke     <= 1'b0;
            r_state <= ST_SELFREF;
          end
          C_PDE: begin
            cke     <= 1'b0;
            r_state <= ST_PWRDN;
          end
          C_ACT: begin
            r_rcd[req_ba]  <= CW'(T_RCD);
            r_open[req_ba] <= 1'b1;
          end
          C_PRE, C_RDAP, C_WRAP: begin
            r_rp[req_ba]   <= CW'(T_RP);
            r_open[req_ba] <= 1'b0;
          end
          C_PREA: begin
            for (int b = 0; b < NB; b++) r_rp[b] <= CW'(T_RP);
            r_open <= '0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DDR3_CMD_CHECK_EN
  logic r_err;
  always_ff @(posedge ck or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_acc && w_drop;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_issue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ddr3_cmd_issue: directed self-checking bench for ddr3_cmd_issue. |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_ddr3_cmd_issue;

  localparam int T_MRD = 4;
  localparam int T_RCD = 6;
  localparam int T_RP  = 6;
  localparam int T_RFC = 64;
  localparam int T_XP  = 4;

`ifdef DDR3_CMD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [3:0] C_NOP = 4'd0, C_MRS = 4'd1, C_REF = 4'd2, C_ACT = 4'd5,
                         C_WR = 4'd6, C_RD = 4'd8, C_RDAP = 4'd9, C_SRE = 4'd12,
                         C_SRX = 4'd13, C_PDE = 4'd14, C_PDX = 4'd15;

  logic        ck;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_cmd;
  logic [2:0]  req_ba;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        err;
  logic        cke;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [15:0] addr;
  logic [3:0]  pins;

  int vectors;
  int miscompares;

  assign pins = {cs_n, ras_n, cas_n, we_n};

  ddr3_cmd_issue dut (
    .ck        (ck),
    .rst       (rst),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ba    (req_ba),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .err       (err),
    .cke       (cke),
    .cs_n      (cs_n),
    .ras_n     (ras_n),
    .cas_n     (cas_n),
    .we_n      (we_n),
    .ba        (ba),
    .addr      (addr)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic drive(input logic v, input logic [3:0] c, input logic [2:0] b,
                       input logic [15:0] a);
    req_valid = v;
    req_cmd   = c;
    req_ba    = b;
    req_addr  = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, C_NOP, 3'd0, 16'h0);
    repeat (2) @(negedge ck);
    vectors++;
    if ({cke, pins} !== 5'b01111) begin
      miscompares++; $display("FAIL reset_pins: got %b expected 01111", {cke, pins});
    end
    vectors++;
    if (ba !== 3'd0 || addr !== 16'h0 || err !== 1'b0) begin
      miscompares++; $display("FAIL reset_bus: got ba=%0h addr=%0h err=%b expected 0/0/0", ba, addr, err);
    end
    rst = 1'b0;
    @(negedge ck); #1;
    drive(1'b0, C_MRS, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_mrs_ready: got %b expected 0", req_ready);
    end
    drive(1'b0, C_NOP, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_nop_ready: got %b expected 0", req_ready);
    end
    drive(1'b0, C_PDX, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_pdx_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_pdx_mrs();
    drive(1'b1, C_PDX, 3'd0, 16'h0);
    @(negedge ck); #1;
    vectors++;
    if ({cke, pins} !== 5'b10111) begin
      miscompares++; $display("FAIL pdx_pins: got %b expected 10111", {cke, pins});
    end
    drive(1'b1, C_MRS, 3'd1, 16'h0123);
    for (int k = 1; k <= T_XP; k++) begin
      #1;
      vectors++;
      if (req_ready !== (k >= T_XP)) begin
        miscompares++; $display("FAIL txp_ready k=%0d: got %b expected %b", k, req_ready, k >= T_XP);
      end
      if (k < T_XP) @(negedge ck);
    end
    @(negedge ck); #1;
    vectors++;
    if (pins !== 4'b0000 || ba !== 3'd1 || addr !== 16'h0123) begin
      miscompares++; $display("FAIL mrs_pins: got %b ba=%0h addr=%0h expected 0000 1 0123", pins, ba, addr);
    end
  endtask

  task automatic test_act_rd();
    drive(1'b1, C_ACT, 3'd2, 16'h1234);
    for (int k = 1; k <= T_MRD; k++) begin
      #1;
      vectors++;
      if (req_ready !== (k >= T_MRD)) begin
        miscompares++; $display("FAIL tmrd_ready k=%0d: got %b expected %b", k, req_ready, k >= T_MRD);
      end
      if (k < T_MRD) @(negedge ck);
    end
    @(negedge ck); #1;
    vectors++;
    if (pins !== 4'b0011 || ba !== 3'd2 || addr !== 16'h1234) begin
      miscompares++; $display("FAIL act_pins: got %b ba=%0h addr=%0h expected 0011 2 1234", pins, ba, addr);
    end
    drive(1'b1, C_RD, 3'd3, 16'h0010); #1;
    vectors++;
    if (req_ready !== CHK) begin
      miscompares++; $display("FAIL rd_closed_ready: got %b expected %b", req_ready, CHK);
    end
    drive(1'b1, C_RD, 3'd2, 16'h0010);
    for (int k = 1; k <= T_RCD; k++) begin
      #1;
      vectors++;
      if (req_ready !== (k >= T_RCD)) begin
        miscompares++; $display("FAIL trcd_ready k=%0d: got %b expected %b", k, req_ready, k >= T_RCD);
      end
      if (k < T_RCD) @(negedge ck);
    end
    @(negedge ck); #1;
    vectors++;
    if (pins !== 4'b0101 || ba !== 3'd2 || addr !== 16'h0010) begin
      miscompares++; $display("FAIL rd_pins: got %b ba=%0h addr=%0h expected 0101 2 0010", pins, ba, addr);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, C_RDAP, 3'd2, 16'h0020); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL rdap_ready: got %b expected 1", req_ready);
    end
    @(negedge ck); #1;
    vectors++;
    if (pins !== 4'b0101 || ba !== 3'd2 || addr !== 16'h0420) begin
      miscompares++; $display("FAIL rdap_pins: got %b ba=%0h addr=%0h expected 0101 2 0420", pins, ba, addr);
    end
    drive(1'b1, C_RD, 3'd2, 16'h0010); #1;
    vectors++;
    if (req_ready !== CHK) begin
      miscompares++; $display("FAIL rd_after_rdap_ready: got %b expected %b", req_ready, CHK);
    end
    drive(1'b1, C_ACT, 3'd2, 16'h0100);
    for (int k = 1; k <= T_RP; k++) begin
      #1;
      vectors++;
      if (req_ready !== (k >= T_RP)) begin
        miscompares++; $display("FAIL trp_ready k=%0d: got %b expected %b", k, req_ready, k >= T_RP);
      end
      if (k < T_RP) @(negedge ck);
      else drive(1'b0, C_NOP, 3'd0, 16'h0);
    end
    @(negedge ck); #1;
  endtask

  task automatic test_ref();
    drive(1'b1, C_REF, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL ref_ready: got %b expected 1", req_ready);
    end
    @(negedge ck);
    drive(1'b0, C_MRS, 3'd0, 16'h0);
    for (int k = 1; k <= T_RFC; k++) begin
      #1;
      vectors++;
      if (pins !== ((k == 1) ? 4'b0001 : 4'b0111)) begin
        miscompares++; $display("FAIL trfc_pins k=%0d: got %b expected %b", k, pins, (k == 1) ? 4'b0001 : 4'b0111);
      end
      vectors++;
      if (req_ready !== (k >= T_RFC)) begin
        miscompares++; $display("FAIL trfc_ready k=%0d: got %b expected %b", k, req_ready, k >= T_RFC);
      end
      if (k == 32) begin
        drive(1'b0, C_NOP, 3'd0, 16'h0); #1;
        vectors++;
        if (req_ready !== 1'b1) begin
          miscompares++; $display("FAIL nop_during_busy: got %b expected 1", req_ready);
        end
        drive(1'b0, C_MRS, 3'd0, 16'h0);
      end
      if (k < T_RFC) @(negedge ck);
    end
    @(negedge ck); #1;
  endtask

  task automatic test_selfref();
    drive(1'b1, C_SRE, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL sre_ready: got %b expected 1", req_ready);
    end
    @(negedge ck); #1;
    vectors++;
    if ({cke, pins} !== 5'b00001) begin
      miscompares++; $display("FAIL sre_pins: got %b expected 00001", {cke, pins});
    end
    drive(1'b1, C_PDX, 3'd0, 16'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge ck); #1;
      vectors++;
      if (req_ready !== 1'b0 || {cke, pins} !== 5'b01111) begin
        miscompares++; $display("FAIL selfref_pdx k=%0d: got ready=%b pins=%b expected 0 01111", k, req_ready, {cke, pins});
      end
    end
    drive(1'b0, C_NOP, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++; $display("FAIL selfref_nop_ready: got %b expected 0", req_ready);
    end
    drive(1'b1, C_SRX, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL srx_ready: got %b expected 1", req_ready);
    end
    @(negedge ck); #1;
    vectors++;
    if ({cke, pins} !== 5'b10111) begin
      miscompares++; $display("FAIL srx_pins: got %b expected 10111", {cke, pins});
    end
    drive(1'b0, C_MRS, 3'd0, 16'h0);
    for (int k = 1; k <= T_XP; k++) begin
      #1;
      vectors++;
      if (req_ready !== (k >= T_XP)) begin
        miscompares++; $display("FAIL srx_txp k=%0d: got %b expected %b", k, req_ready, k >= T_XP);
      end
      if (k < T_XP) @(negedge ck);
    end
    @(negedge ck); #1;
  endtask

  task automatic test_powerdown();
    drive(1'b1, C_PDE, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL pde_ready: got %b expected 1", req_ready);
    end
    @(negedge ck); #1;
    vectors++;
    if ({cke, pins} !== 5'b00111) begin
      miscompares++; $display("FAIL pde_pins: got %b expected 00111", {cke, pins});
    end
    drive(1'b1, C_SRX, 3'd0, 16'h0);
    @(negedge ck); #1;
    vectors++;
    if (req_ready !== 1'b0 || {cke, pins} !== 5'b01111) begin
      miscompares++; $display("FAIL pwrdn_srx: got ready=%b pins=%b expected 0 01111", req_ready, {cke, pins});
    end
    drive(1'b1, C_PDX, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL pwrdn_pdx_ready: got %b expected 1", req_ready);
    end
    @(negedge ck); #1;
    vectors++;
    if ({cke, pins} !== 5'b10111) begin
      miscompares++; $display("FAIL pdx2_pins: got %b expected 10111", {cke, pins});
    end
  endtask

  task automatic test_check();
    drive(1'b1, C_WR, 3'd5, 16'h0040);
    for (int k = 1; k <= T_XP; k++) begin
      #1;
      vectors++;
      if (req_ready !== (CHK && (k >= T_XP))) begin
        miscompares++; $display("FAIL wr_closed_ready k=%0d: got %b expected %b", k, req_ready, CHK && (k >= T_XP));
      end
      if (k < T_XP) @(negedge ck);
      else if (!CHK) drive(1'b0, C_NOP, 3'd0, 16'h0);
    end
    @(negedge ck); #1;
    drive(1'b0, C_NOP, 3'd0, 16'h0);
    vectors++;
    if (pins !== 4'b0111 || err !== CHK) begin
      miscompares++; $display("FAIL wr_closed_drop: got pins=%b err=%b expected 0111 %b", pins, err, CHK);
    end
    @(negedge ck); #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL err_pulse_width: got %b expected 0", err);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, C_ACT, 3'd0, 16'h0055); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL act0_ready: got %b expected 1", req_ready);
    end
    @(negedge ck); #1;
    drive(1'b0, C_NOP, 3'd0, 16'h0);
    vectors++;
    if (pins !== 4'b0011 || addr !== 16'h0055) begin
      miscompares++; $display("FAIL act0_pins: got %b addr=%0h expected 0011 0055", pins, addr);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({cke, pins} !== 5'b01111 || addr !== 16'h0) begin
      miscompares++; $display("FAIL async_rst_pins: got %b addr=%0h expected 01111 0", {cke, pins}, addr);
    end
    drive(1'b0, C_ACT, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++; $display("FAIL async_rst_act_ready: got %b expected 0", req_ready);
    end
    @(negedge ck);
    rst = 1'b0;
    drive(1'b0, C_PDX, 3'd0, 16'h0); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL post_rst_pdx_ready: got %b expected 1", req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    drive(1'b0, C_NOP, 3'd0, 16'h0);
    test_reset();
    test_pdx_mrs();
    test_act_rd();
    test_back_to_back();
    test_ref();
    test_selfref();
    test_powerdown();
    test_check();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
